// File: rtl/bist_sched_pkg.sv
// Shared definitions for the BIST scheduler: state encoding and default sizing.
package bist_sched_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int TIMEOUT_DEF = 200;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RUN     = 3'd1;
  localparam logic [2:0] ST_DONE    = 3'd2;
  localparam logic [2:0] ST_ERR     = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_RUN     = ST_RUN,
    S_DONE    = ST_DONE,
    S_ERR     = ST_ERR,
    S_RELEASE = ST_RELEASE
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts one past the previous winner.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_last_winner,
  output logic [NUM_REQ-1:0] o_winner,
  output logic [IW-1:0]      o_index
);

  logic          w_found;
  logic [IW-1:0] w_k;

  always_comb begin
    o_winner = '0;
    o_index  = '0;
    w_found  = 1'b0;
    w_k      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_k = IW'((int'(i_last_winner) + i) % NUM_REQ);
      if (!w_found && i_req[w_k]) begin
        w_found       = 1'b1;
        o_winner[w_k] = 1'b1;
        o_index       = w_k;
      end
    end
  end

endmodule

// File: rtl/bist_scheduler.sv
// Shares one BIST engine between NUM_REQ requesters; all outputs are registered
// and computed from the next state so they change on the same edge as the FSM.
module bist_scheduler
  import bist_sched_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic               bist_start,
  input  logic               bist_end,
  output logic [NUM_REQ-1:0] done,
  output logic               timeout_err,
  output logic               busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t             r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic [IW-1:0]      r_last, w_last_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic [NUM_REQ-1:0] r_done, w_done_nxt;
  logic               r_start, w_start_nxt;
  logic               r_terr, w_terr_nxt;
  logic               r_busy, w_busy_nxt;
  logic [NUM_REQ-1:0] w_arb_gnt;
  logic [IW-1:0]      w_arb_idx;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .i_req         (req),
    .i_last_winner (r_last),
    .o_winner      (w_arb_gnt),
    .o_index       (w_arb_idx)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    w_grant_nxt = r_grant;
    w_done_nxt  = '0;
    w_start_nxt = 1'b0;
    w_terr_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_grant_nxt = '0;
        if (|req) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
          w_last_nxt  = w_arb_idx;
          w_grant_nxt = w_arb_gnt;
          w_start_nxt = 1'b1;
        end
      end
      S_RUN: begin
        // Completion has priority over the timeout on the same cycle.
        if (bist_end) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = r_grant;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_ERR;
          w_terr_nxt  = 1'b1;
        end else begin
          w_start_nxt = 1'b1;
          if (r_cnt != {CW{1'b1}}) w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_DONE, S_ERR: begin
        w_state_nxt = S_RELEASE;
        w_grant_nxt = '0;
      end
      S_RELEASE: begin
        // Hold off until the engine drops bist_end so it cannot end the next run.
        w_grant_nxt = '0;
        if (!bist_end) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt   <= '0;
      r_last  <= IW'(NUM_REQ - 1);
      r_grant <= '0;
      r_done  <= '0;
      r_start <= 1'b0;
      r_terr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
      r_grant <= w_grant_nxt;
      r_done  <= w_done_nxt;
      r_start <= w_start_nxt;
      r_terr  <= w_terr_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign grant       = r_grant;
  assign done        = r_done;
  assign bist_start  = r_start;
  assign timeout_err = r_terr;
  assign busy        = r_busy;

endmodule
